mem_bus_arbiter: RTL and testbench

Round-robin arbiter and serial sequencer that shares the single-wire memory subsystem bus between NUM_REQ requesters. It grants one requester at a time and serializes that requester's read or write into the start/address/rw/data/stop frame on sda_out. It watches the memory's ack_n, returns read data, and reports completion or timeout per requester. It sits between the client blocks and the I2C-style memory controller.

---
 rtl/mem_bus_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the single-wire memory bus.
// Grants one requester and serializes its access as a start/addr/rw/data/stop frame.
module mem_bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 4,
    parameter int READ_LAT    = 2,
    parameter int STOP_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic                          sda_out,
    input  logic                          ack_n,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AIW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int DIW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CW  = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_RW,
        S_AACK,
        S_WGAP,
        S_DATA,
        S_DACK,
        S_RWAIT,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    eflag_q, eflag_d;
    logic [NUM_REQ-1:0]      gnt_d;
    logic [NUM_REQ-1:0]      done_d;
    logic                    err_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    sda_d;
    logic                    last_stop;

    logic                    found;
    logic [PW-1:0]           win;
    logic [PW-1:0]           idx;

    assign busy = (state_q != S_IDLE);

    // First asserted request at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        eflag_d = eflag_q;
        gnt_d   = gnt;
        rdata_d = rdata;
        unique case (state_q)
            S_IDLE: begin
                eflag_d = 1'b0;
                if (found) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    gnt_d   = NUM_REQ'(1) << win;
                    ptr_d   = (int'(win) == NUM_REQ - 1) ?
                              '0 : win + PW'(1);
                    rw_d    = req_rw[win];
                    addr_d  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            S_START: begin
                state_d = S_ADDR;
                cnt_d   = '0;
            end
            S_ADDR: begin
                if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                    state_d = S_RW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RW: begin
                cnt_d = '0;
                if (!ack_n) begin
                    state_d = rw_q ? S_WGAP : S_RWAIT;
                end else begin
                    state_d = S_AACK;
                end
            end
            S_AACK: begin
                if (!ack_n) begin
                    state_d = rw_q ? S_WGAP : S_RWAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    eflag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WGAP: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d = ack_n ? S_DACK : S_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DACK: begin
                if (!ack_n) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    eflag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RWAIT: begin
                if (cnt_q == CW'(READ_LAT - 1)) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(STOP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    gnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
            end
        endcase
    end

    // Line and pulse outputs are registered from the state being entered.
    always_comb begin
        sda_d = 1'b1;
        unique case (state_d)
            S_IDLE, S_STOP:                  sda_d = 1'b1;
            S_START, S_AACK, S_WGAP,
            S_DACK, S_RWAIT:                 sda_d = 1'b0;
            S_ADDR:  sda_d = addr_d[cnt_d[AIW-1:0]];
            S_RW:    sda_d = rw_d;
            S_DATA:  sda_d = wdata_d[cnt_d[DIW-1:0]];
            default: sda_d = 1'b1;
        endcase
        last_stop = (state_d == S_STOP) &&
                    (cnt_d == CW'(STOP_CYCLES - 1));
        done_d    = last_stop ? gnt_d : '0;
        err_d     = last_stop & eflag_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            eflag_q <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            err     <= 1'b0;
            rdata   <= '0;
            sda_out <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            eflag_q <= eflag_d;
            gnt     <= gnt_d;
            done    <= done_d;
            err     <= err_d;
            rdata   <= rdata_d;
            sda_out <= sda_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: frame-level reference model for the bus arbiter.
// Expected frames are built from the protocol rules, not the state machine.
module tb_mem_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int TO = 4;
    localparam int RL = 2;
    localparam int SC = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      req_rw = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_wdata = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic              err;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic              sda_out;
    logic              ack_n = 1'b1;
    logic [DW-1:0]     mem_rdata = '0;

    int            passed = 0;
    int            total = 0;
    int            model_ptr = 0;
    logic [DW-1:0] model_rdata = '0;

    bit exp_q[$];
    int ack_a;
    int ack_d;
    int cap_cyc;
    bit exp_err;

    mem_bus_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ACK_TIMEOUT(TO), .READ_LAT(RL), .STOP_CYCLES(SC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
        .done(done), .err(err), .rdata(rdata), .busy(busy),
        .sda_out(sda_out), .ack_n(ack_n), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Frame for one transaction; ad/dd = cycles after RW / last data bit
    // at which ack_n is driven low, anything above TO means never.
    task automatic build(input bit rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int ad,
                         input int dd);
        exp_q.delete();
        ack_a = -1;
        ack_d = -1;
        cap_cyc = -1;
        exp_err = 0;
        exp_q.push_back(1'b0);
        for (int k = 0; k < AW; k++) exp_q.push_back(a[k]);
        exp_q.push_back(rw);
        if (ad > TO) begin
            repeat (TO) exp_q.push_back(1'b0);
            exp_err = 1;
        end else begin
            ack_a = exp_q.size() - 1 + ad;
            repeat (ad) exp_q.push_back(1'b0);
            if (rw) begin
                repeat (2) exp_q.push_back(1'b0);
                for (int k = 0; k < DW; k++) exp_q.push_back(d[k]);
                if (dd > TO) begin
                    repeat (TO) exp_q.push_back(1'b0);
                    exp_err = 1;
                end else begin
                    ack_d = exp_q.size() - 1 + dd;
                    repeat (dd) exp_q.push_back(1'b0);
                end
            end else begin
                repeat (RL) exp_q.push_back(1'b0);
                cap_cyc = exp_q.size() - 1;
            end
        end
        repeat (SC) exp_q.push_back(1'b1);
    endtask

    task automatic run_txn(input int who, input bit rw,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int ad, input int dd,
                           input logic [DW-1:0] mv, input string tag);
        bit got;
        logic [N-1:0] oh;
        logic [N-1:0] exp_done;
        bit exp_e;
        int last;
        build(rw, a, d, ad, dd);
        last = exp_q.size() - 1;
        oh = N'(1) << who;
        @(negedge clk);
        req_rw[who] = rw;
        req_addr[who*AW +: AW] = a;
        req_wdata[who*DW +: DW] = d;
        req[who] = 1'b1;
        ack_n = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (gnt != '0);
        end
        total++;
        if (gnt !== oh) begin
            $display("FAIL %s grant: gnt=%b expected %b", tag, gnt, oh);
        end else passed++;
        if (!got) begin
            req = '0;
            return;
        end
        model_ptr = (who + 1) % N;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            ack_n = !(c == ack_a || c == ack_d);
            mem_rdata = (c == cap_cyc) ? mv : ~mv;
            exp_done = (c == last) ? oh : '0;
            exp_e = (c == last) && exp_err;
            total++;
            if (sda_out !== exp_q[c]) begin
                $display("FAIL %s sda cyc %0d: got %b expected %b",
                         tag, c, sda_out, exp_q[c]);
            end else passed++;
            total++;
            if (done !== exp_done || err !== exp_e) begin
                $display("FAIL %s done/err cyc %0d: got %b/%b expected %b/%b",
                         tag, c, done, err, exp_done, exp_e);
            end else passed++;
            total++;
            if (gnt !== oh || busy !== 1'b1) begin
                $display("FAIL %s hold cyc %0d: gnt=%b busy=%b expected %b/1",
                         tag, c, gnt, busy, oh);
            end else passed++;
        end
        req[who] = 1'b0;
        ack_n = 1'b1;
        if (!rw && !exp_err) model_rdata = mv;
        @(negedge clk);
        total++;
        if (gnt !== '0 || busy !== 1'b0 || sda_out !== 1'b1) begin
            $display("FAIL %s idle: gnt=%b busy=%b sda=%b expected 0/0/1",
                     tag, gnt, busy, sda_out);
        end else passed++;
        total++;
        if (rdata !== model_rdata) begin
            $display("FAIL %s rdata: got %h expected %h",
                     tag, rdata, model_rdata);
        end else passed++;
    endtask

    task automatic arb_seq(input logic [N-1:0] mask, input bit hold,
                           input int n, input string tag);
        logic [N-1:0] pend;
        int w;
        int gap;
        int seen;
        bit prev_g;
        bit fnd;
        pend = mask;
        req_rw = '0;
        mem_rdata = 8'h5A;
        ack_n = 1'b0;
        @(negedge clk);
        req = pend;
        seen = 0;
        gap = -1;
        prev_g = 0;
        for (int cyc = 0; cyc < 400 && seen < n; cyc++) begin
            @(negedge clk);
            if (gnt != '0 && !prev_g) begin
                w = 0;
                fnd = 0;
                for (int k = 0; k < N; k++) begin
                    if (!fnd && pend[(model_ptr + k) % N]) begin
                        fnd = 1;
                        w = (model_ptr + k) % N;
                    end
                end
                total++;
                if (gnt !== N'(1) << w) begin
                    $display("FAIL %s order #%0d: gnt=%b expected %b",
                             tag, seen, gnt, N'(1) << w);
                end else passed++;
                if (gap >= 0) begin
                    total++;
                    if (gap != 1) begin
                        $display("FAIL %s gap #%0d: idle %0d expected 1",
                                 tag, seen, gap);
                    end else passed++;
                end
                model_ptr = (w + 1) % N;
                seen++;
            end
            if (gnt == '0 && gap >= 0) gap++;
            if (done != '0) begin
                gap = 0;
                if (!hold) pend = pend & ~done;
                req = pend;
            end
            prev_g = (gnt != '0);
        end
        total++;
        if (seen < n) begin
            $display("FAIL %s grants: got %0d expected %0d", tag, seen, n);
        end else passed++;
        for (int i = 0; i < 60 && done == '0; i++) @(negedge clk);
        req = '0;
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        ack_n = 1'b1;
        model_rdata = 8'h5A;
        total++;
        if (busy !== 1'b0 || rdata !== model_rdata) begin
            $display("FAIL %s end: busy=%b rdata=%h expected 0/%h",
                     tag, busy, rdata, model_rdata);
        end else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = '0;
        ack_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({gnt, done, err, rdata, busy, sda_out} !==
            {4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            $display("FAIL reset: gnt=%b done=%b err=%b rdata=%h busy=%b sda=%b",
                     gnt, done, err, rdata, busy, sda_out);
        end else passed++;
        reset_n = 1'b1;
        model_ptr = 0;
        model_rdata = '0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || gnt !== '0 || sda_out !== 1'b1) begin
            $display("FAIL idle_no_req: busy=%b gnt=%b sda=%b expected 0/0/1",
                     busy, gnt, sda_out);
        end else passed++;
    endtask

    task automatic test_arbitration();
        arb_seq(4'b0101, 1'b0, 2, "arb_pair");
        arb_seq(4'b1111, 1'b1, 5, "arb_all");
    endtask

    task automatic test_write_frame();
        run_txn(1, 1'b1, 7'h05, 8'hA5, 0, 0, 8'h00, "write");
    endtask

    task automatic test_read();
        run_txn(3, 1'b0, 7'h64, 8'h00, 0, 0, 8'h3C, "read");
        run_txn(0, 1'b1, 7'h11, 8'h7E, 2, 3, 8'hC3, "wr_hold");
        run_txn(2, 1'b0, 7'h3A, 8'h00, TO, 0, 8'hE1, "read_late");
    endtask

    task automatic test_timeout();
        run_txn(2, 1'b1, 7'h2D, 8'hFF, TO + 1, 0, 8'h99, "to_addr");
        run_txn(1, 1'b1, 7'h40, 8'h0F, 1, TO + 1, 8'h66, "to_data");
        run_txn(0, 1'b0, 7'h7F, 8'h00, TO + 1, 0, 8'h44, "to_read");
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            run_txn($urandom_range(0, N - 1), 1'($urandom_range(0, 1)),
                    AW'($urandom), DW'($urandom),
                    $urandom_range(0, TO + 1), $urandom_range(0, TO + 1),
                    DW'($urandom), "rnd");
        end
    endtask

    task automatic test_reset_midframe();
        bit got;
        logic [DW-1:0] wd;
        wd = 8'h96;
        @(negedge clk);
        ack_n = 1'b0;
        req_rw[0] = 1'b1;
        req_addr[0 +: AW] = 7'h2B;
        req_wdata[0 +: DW] = wd;
        req = 4'b0001;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (gnt != '0);
        end
        total++;
        if (gnt !== 4'b0001) begin
            $display("FAIL midrst grant: gnt=%b expected 0001", gnt);
        end else passed++;
        req[2] = 1'b1;
        req_rw[2] = 1'b0;
        repeat (14) @(negedge clk);
        total++;
        if (sda_out !== wd[3] || busy !== 1'b1) begin
            $display("FAIL midrst bit4: sda=%b busy=%b expected %b/1",
                     sda_out, busy, wd[3]);
        end else passed++;
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({sda_out, gnt, busy, done, err, rdata} !==
            {1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00}) begin
            $display("FAIL midrst async: sda=%b gnt=%b busy=%b done=%b err=%b rdata=%h",
                     sda_out, gnt, busy, done, err, rdata);
        end else passed++;
        model_ptr = 0;
        model_rdata = '0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001 || sda_out !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL midrst restart: gnt=%b sda=%b busy=%b expected 0001/0/1",
                     gnt, sda_out, busy);
        end else passed++;
        req = '0;
        ack_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_write_frame();
        test_read();
        test_timeout();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
